// File: rtl/bcd_pkg.sv
// Shared definitions for the serial binary-to-BCD converter: digit width,
// FSM state encoding and the elaboration-time digit-count helper.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Smallest digit count d with 10^d >= 2^width.
  function automatic int min_digits(input int width);
    longint unsigned lim;
    longint unsigned pow10;
    int              d;
    lim   = 64'd1 << width;
    pow10 = 64'd10;
    d     = 1;
    while (pow10 < lim) begin
      pow10 = pow10 * 64'd10;
      d     = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble adjust cell: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bcd_serial_convert.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one operand bit per clock,
// with start/done handshake and optional two's-complement input.
module bcd_serial_convert
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      neg
);

  localparam int ACC_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (BIN_W < 2) begin : g_bad_width
    $error("bcd_serial_convert: BIN_W must be at least 2");
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
    $error("bcd_serial_convert: DIGITS too small to hold 2^BIN_W-1");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   op_q, op_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               sign_q, sign_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;

  logic [ACC_W-1:0]       acc_adj;
  logic [ACC_W+BIN_W-1:0] cat_shift;
  logic [BIN_W-1:0]       bin_mag;
  logic                   bin_sign;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit_i (acc_q[DIGIT_W*k +: DIGIT_W]),
      .digit_o (acc_adj[DIGIT_W*k +: DIGIT_W])
    );
  end

  // The most negative input negates to itself, which read unsigned is the
  // correct magnitude 2^(BIN_W-1).
  assign bin_sign  = (SIGNED != 0) && bin[BIN_W-1];
  assign bin_mag   = bin_sign ? (~bin + 1'b1) : bin;
  assign cat_shift = {acc_adj, op_q} << 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(BIN_W);
          op_d    = bin_mag;
          acc_d   = '0;
          sign_d  = bin_sign;
        end
      end
      SHIFT: begin
        acc_d = cat_shift[ACC_W+BIN_W-1:BIN_W];
        op_d  = cat_shift[BIN_W-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          bcd_d   = cat_shift[ACC_W+BIN_W-1:BIN_W];
          neg_d   = sign_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign neg  = (SIGNED != 0) ? neg_q : 1'b0;

endmodule

// File: tb/tb_bcd_serial_convert.sv
// Directed bench for bcd_serial_convert: unsigned 8-bit, signed 8-bit and
// exhaustive unsigned 5-bit instances sharing one clock and reset.
module tb_bcd_serial_convert;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  start_v = 3'b000;
  logic [7:0]  bin_u = '0;
  logic [7:0]  bin_s = '0;
  logic [4:0]  bin_5 = '0;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  neg_v;
  logic [11:0] bcd_u;
  logic [11:0] bcd_s;
  logic [7:0]  bcd_5;

  // Expected results as {neg, bcd[11:0]}.
  logic [12:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Clock / reset
  always #5 clk = ~clk;

  bcd_serial_convert #(.BIN_W(8), .DIGITS(3), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .bin(bin_u),
    .busy(busy_v[0]), .done(done_v[0]), .bcd(bcd_u), .neg(neg_v[0])
  );

  bcd_serial_convert #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .bin(bin_s),
    .busy(busy_v[1]), .done(done_v[1]), .bcd(bcd_s), .neg(neg_v[1])
  );

  bcd_serial_convert #(.BIN_W(5), .DIGITS(2), .SIGNED(0)) u_dut_5 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .bin(bin_5),
    .busy(busy_v[2]), .done(done_v[2]), .bcd(bcd_5), .neg(neg_v[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [12:0] result_of(input int sel);
    case (sel)
      0:       return {neg_v[0], bcd_u};
      1:       return {neg_v[1], bcd_s};
      default: return {neg_v[2], 4'h0, bcd_5};
    endcase
  endfunction

  // Drivers: present operand and start now, release after the accepting edge.
  task automatic drive_now(input int sel, input logic [7:0] v);
    case (sel)
      0:       bin_u = v;
      1:       bin_s = v;
      default: bin_5 = v[4:0];
    endcase
    start_v[sel] = 1'b1;
    @(posedge clk);
    #1 start_v[sel] = 1'b0;
  endtask

  task automatic drive_start(input int sel, input logic [7:0] v);
    @(negedge clk);
    drive_now(sel, v);
  endtask

  // Counts edges after the accept edge (cyc0 already elapsed) until done.
  task automatic wait_done(input int sel, input int lat, input int cyc0);
    int cyc;
    bit seen;
    cyc  = cyc0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) check("busy_running", busy_v[sel], 1'b1);
      if (done_v[sel]) seen = 1'b1;
    end
    check("done_seen", seen, 1'b1);
    if (seen) begin
      check("latency", cyc, lat);
      check("busy_in_done", busy_v[sel], 1'b0);
      if (exp_q.size() > 0) check("result", result_of(sel), exp_q.pop_front());
      else check("exp_q_underflow", 1, 0);
    end
  endtask

  task automatic convert(input int sel, input logic [7:0] v, input int lat,
                         input logic [11:0] exp_bcd, input logic exp_neg);
    exp_q.push_back({exp_neg, exp_bcd});
    drive_start(sel, v);
    wait_done(sel, lat, 0);
  endtask

  task automatic expect_quiet(input int sel, input int ncyc, input string tag);
    int pulses;
    pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done_v[sel]) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {29'd0, busy_v}, 0);
    check("rst_done", {29'd0, done_v}, 0);
    check("rst_neg", {29'd0, neg_v}, 0);
    check("rst_bcd_u", bcd_u, 0);
    check("rst_bcd_s", bcd_s, 0);
    check("rst_bcd_5", bcd_5, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Unsigned 8-bit main function
    convert(0, 8'd255, 8, 12'h255, 1'b0);
    convert(0, 8'd0,   8, 12'h000, 1'b0);
    convert(0, 8'd99,  8, 12'h099, 1'b0);

    // Start accepted in the done cycle
    convert(0, 8'd128, 8, 12'h128, 1'b0);
    exp_q.push_back({1'b0, 12'h007});
    drive_now(0, 8'd7);
    wait_done(0, 8, 0);

    // Start pulse mid-conversion is ignored and not queued
    exp_q.push_back({1'b0, 12'h128});
    drive_start(0, 8'd128);
    repeat (3) @(negedge clk);
    bin_u = 8'd55;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 8, 3);
    expect_quiet(0, 12, "no_queued_done");
    check("bcd_held", bcd_u, 12'h128);

    // Reset mid-conversion aborts with outputs cleared
    drive_start(0, 8'd200);
    repeat (4) @(negedge clk);
    check("busy_before_rst", busy_v[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy_v[0], 1'b0);
    check("abort_done", done_v[0], 1'b0);
    check("abort_bcd", bcd_u, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet(0, 12, "no_done_after_abort");
    convert(0, 8'd200, 8, 12'h200, 1'b0);

    // Signed 8-bit
    convert(1, 8'h80, 8, 12'h128, 1'b1);
    convert(1, 8'hF6, 8, 12'h010, 1'b1);
    convert(1, 8'h7F, 8, 12'h127, 1'b0);
    convert(1, 8'h00, 8, 12'h000, 1'b0);
    convert(1, 8'hFF, 8, 12'h001, 1'b1);

    // Exhaustive 5-bit against a divide/modulo reference
    for (int v = 0; v < 32; v++) begin
      convert(2, 8'(v), 5, {4'h0, 4'(v / 10), 4'(v % 10)}, 1'b0);
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
